// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
// Optional feature macro used by the unit: MULDIV_DIVZERO_EN (divide-by-zero bypass).
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;
  localparam int unsigned MULDIV_ITER  = 32;

  typedef enum logic [2:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    DIV_FIX,
    DONE
  } state_e;

  // Source of the value loaded into the HI/LO result registers
  typedef enum logic [1:0] {
    RES_HOLD,
    RES_MULT,
    RES_DIV,
    RES_DIVZ
  } res_sel_e;

endpackage

// File: rtl/booth_mult_core.sv
// Radix-2 Booth multiplier datapath: one recoded bit per step, exposes the
// post-step product so the owner can capture the final value on the last step.
module booth_mult_core
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [WIDTH-1:0]     mplier_i,
  output logic [2*WIDTH-1:0]   prod_nxt_o
);

  // One guard bit on the accumulator keeps +/-(-2^(W-1)) from overflowing
  logic [WIDTH:0]   acc_q, acc_d, acc_sum, mcand_ext;
  logic [WIDTH-1:0] mq_q, mq_d, mcand_q, mcand_d;
  logic             qm1_q, qm1_d;

  always_comb begin
    mcand_ext = {mcand_q[WIDTH-1], mcand_q};
    unique case ({mq_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + mcand_ext;
      2'b10:   acc_sum = acc_q - mcand_ext;
      default: acc_sum = acc_q;
    endcase

    acc_d   = acc_q;
    mq_d    = mq_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    if (load_i) begin
      acc_d   = '0;
      mq_d    = mplier_i;
      qm1_d   = 1'b0;
      mcand_d = mcand_i;
    end else if (step_i) begin
      acc_d = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
      mq_d  = {acc_sum[0], mq_q[WIDTH-1:1]};
      qm1_d = mq_q[0];
    end
  end

  assign prod_nxt_o = {acc_d[WIDTH-1:0], mq_d};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
    end else begin
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Sequential signed multiply/divide engine with registered done strobes and
// held HI/LO results. Define MULDIV_DIVZERO_EN for the single-cycle divide-by-zero path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             mult_done,
  output logic             div_done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  res_sel_e         res_sel;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d, a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, mdone_q, mdone_d, ddone_q, ddone_d;
  logic [WIDTH:0]   rem_shift, rem_sub;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic             booth_load, booth_step;
  logic [2*WIDTH-1:0] booth_prod;
`ifdef MULDIV_DIVZERO_EN
  logic             dz_q, dz_d;
`endif

  booth_mult_core #(.WIDTH(WIDTH)) u_booth (
    .clk        (clk),
    .reset      (reset),
    .load_i     (booth_load),
    .step_i     (booth_step),
    .mcand_i    (op_a),
    .mplier_i   (op_b),
    .prod_nxt_o (booth_prod)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    booth_load = 1'b0;
    booth_step = 1'b0;
    res_sel    = RES_HOLD;
    mdone_d    = 1'b0;
    ddone_d    = 1'b0;
`ifdef MULDIV_DIVZERO_EN
    dz_d       = dz_q;
`endif

    a_mag     = op_a[WIDTH-1] ? -op_a : op_a;
    b_mag     = op_b[WIDTH-1] ? -op_b : op_b;
    // Dividend bits stream out of the quotient register's MSB into the remainder
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    quo_fix   = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
    rem_fix   = a_neg_q ? -rem_q : rem_q;

    unique case (state_q)
      IDLE: begin
        if (mult_start || div_start) begin
          is_div_d = !mult_start;
          cnt_d    = CW'(WIDTH);
          a_neg_d  = op_a[WIDTH-1];
          b_neg_d  = op_b[WIDTH-1];
`ifdef MULDIV_DIVZERO_EN
          dz_d     = 1'b0;
`endif
          if (mult_start) begin
            state_d    = MULT_RUN;
            booth_load = 1'b1;
          end else begin
            state_d = DIV_RUN;
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
`ifdef MULDIV_DIVZERO_EN
            if (op_b == '0) begin
              state_d = DONE;
              res_sel = RES_DIVZ;
              dz_d    = 1'b1;
              ddone_d = 1'b1;
            end
`endif
          end
        end
      end
      MULT_RUN: begin
        booth_step = 1'b1;
        cnt_d      = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          res_sel = RES_MULT;
          mdone_d = 1'b1;
        end
      end
      DIV_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (!rem_sub[WIDTH]) begin
          rem_d = rem_sub[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CW'(1)) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        state_d = DONE;
        res_sel = RES_DIV;
        ddone_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    hi_d = hi_q;
    lo_d = lo_q;
    unique case (res_sel)
      RES_MULT: {hi_d, lo_d} = booth_prod;
      RES_DIV: begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end
      RES_DIVZ: begin
        hi_d = op_a;
        lo_d = '1;
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      mdone_q  <= 1'b0;
      ddone_q  <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      mdone_q  <= mdone_d;
      ddone_q  <= ddone_d;
`ifdef MULDIV_DIVZERO_EN
      dz_q     <= dz_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign mult_done = mdone_q;
  assign div_done  = ddone_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
`ifdef MULDIV_DIVZERO_EN
  assign div_by_zero = dz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model compared every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, mult_done, div_done, div_by_zero;
  logic [31:0] hi_out, lo_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

`ifdef MULDIV_DIVZERO_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .mult_start  (mult_start),
    .div_start   (div_start),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .mult_done   (mult_done),
    .div_done    (div_done),
    .div_by_zero (div_by_zero),
    .hi_out      (hi_out),
    .lo_out      (lo_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: an operation is a countdown to its latency, with the result
  // computed from plain signed 64-bit arithmetic at acceptance.
  bit          m_active = 1'b0, m_is_mul = 1'b0, m_was, m_done_now;
  int          m_t = 0, m_lat = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_busy = 1'b0, m_mdone = 1'b0, m_ddone = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  longint      sa, sb, prod, quo, rem;
  bit          cmp_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
      m_busy = 1'b0; m_mdone = 1'b0; m_ddone = 1'b0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0;
    end else begin
      m_was = m_active;
      if (m_active) begin
        if (m_t == m_lat) m_active = 1'b0;
        else m_t++;
      end
      if (!m_was && (mult_start || div_start)) begin
        m_active = 1'b1;
        m_t      = 1;
        m_is_mul = mult_start;
        m_dz     = 1'b0;
        sa = longint'($signed(op_a));
        sb = longint'($signed(op_b));
        p_dz = 1'b0;
        if (m_is_mul) begin
          prod = sa * sb;
          p_hi = prod[63:32];
          p_lo = prod[31:0];
          m_lat = 33;
        end else if (sb == 0) begin
          p_hi = op_a;
          p_lo = 32'hFFFF_FFFF;
          p_dz = DZ_EN;
          m_lat = DZ_EN ? 1 : 34;
        end else begin
          quo = sa / sb;
          rem = sa % sb;
          p_hi = rem[31:0];
          p_lo = quo[31:0];
          m_lat = 34;
        end
      end
      m_done_now = m_active && (m_t == m_lat);
      m_busy  = m_active;
      m_mdone = m_done_now && m_is_mul;
      m_ddone = m_done_now && !m_is_mul;
      if (m_done_now) begin
        m_hi = p_hi;
        m_lo = p_lo;
        m_dz = p_dz;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",        {31'b0, busy},        {31'b0, m_busy});
      check("mult_done",   {31'b0, mult_done},   {31'b0, m_mdone});
      check("div_done",    {31'b0, div_done},    {31'b0, m_ddone});
      check("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dz});
      check("hi_out",      hi_out,               m_hi);
      check("lo_out",      lo_out,               m_lo);
    end
  end

  // Starts in the current cycle (cycle 0) and returns in the done cycle;
  // lat is the done cycle index, or 60 if no strobe appeared.
  task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output int lat);
    op_a = a; op_b = b; mult_start = m; div_start = d;
    @(posedge clk); #1;
    mult_start = 1'b0; div_start = 1'b0;
    lat = 1;
    while (!(mult_done || div_done) && lat < 60) begin
      div_start = (lat == inj);
      @(posedge clk); #1;
      lat++;
    end
    div_start = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);

    // 7 * -3
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1, lat);
    check("t1_lat", lat, 32'd33);
    check("t1_mdone", {31'b0, mult_done}, 32'd1);
    check("t1_hi", hi_out, 32'hFFFF_FFFF);
    check("t1_lo", lo_out, 32'hFFFF_FFEB);
    next_cycle();
    check("t1_busy_after", {31'b0, busy}, 32'd0);

    // max positive squared, stray div_start in cycle 5
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5, lat);
    check("t2_lat", lat, 32'd33);
    check("t2_ddone", {31'b0, div_done}, 32'd0);
    check("t2_hi", hi_out, 32'h3FFF_FFFF);
    check("t2_lo", lo_out, 32'h0000_0001);
    next_cycle();

    // -7 / 2
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, lat);
    check("t3_lat", lat, 32'd34);
    check("t3_ddone", {31'b0, div_done}, 32'd1);
    check("t3_lo", lo_out, 32'hFFFF_FFFD);
    check("t3_hi", hi_out, 32'hFFFF_FFFF);
    next_cycle();

    // overflow divide
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat);
    check("t4_lat", lat, 32'd34);
    check("t4_lo", lo_out, 32'h8000_0000);
    check("t4_hi", hi_out, 32'h0000_0000);
    next_cycle();

    // simultaneous starts: multiply wins
    run_op(1'b1, 1'b1, 32'd3, 32'hFFFF_FFFB, -1, lat);
    check("t4b_lat", lat, 32'd33);
    check("t4b_mdone", {31'b0, mult_done}, 32'd1);
    check("t4b_hi", hi_out, 32'hFFFF_FFFF);
    check("t4b_lo", lo_out, 32'hFFFF_FFF1);
    repeat (3) next_cycle();

    // 100 / -7 and min-negative squared
    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, -1, lat);
    check("x1_lo", lo_out, 32'hFFFF_FFF2);
    check("x1_hi", hi_out, 32'd2);
    next_cycle();
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1, lat);
    check("x2_hi", hi_out, 32'h4000_0000);
    check("x2_lo", lo_out, 32'h0000_0000);
    next_cycle();

`ifdef MULDIV_DIVZERO_EN
    run_op(1'b0, 1'b1, 32'd5, 32'd0, -1, lat);
    check("t5_lat", lat, 32'd1);
    check("t5_dz", {31'b0, div_by_zero}, 32'd1);
    check("t5_hi", hi_out, 32'd5);
    check("t5_lo", lo_out, 32'hFFFF_FFFF);
    next_cycle();
    check("t5_dz_hold", {31'b0, div_by_zero}, 32'd1);
    run_op(1'b1, 1'b0, 32'd2, 32'd3, -1, lat);
    check("t5_dz_clr", {31'b0, div_by_zero}, 32'd0);
    check("t5_lo2", lo_out, 32'd6);
    next_cycle();
`endif

    // reset in cycle 10 of a multiply
    op_a = 32'd9; op_b = 32'd11; mult_start = 1'b1;
    next_cycle();
    mult_start = 1'b0;
    for (int i = 1; i < 10; i++) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_hi", hi_out, 32'd0);
    check("t6_lo", lo_out, 32'd0);
    check("t6_mdone", {31'b0, mult_done}, 32'd0);
    run_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd21, -1, lat);
    check("t6_lat", lat, 32'd33);
    check("t6_hi2", hi_out, 32'hFFFF_FFFF);
    check("t6_lo2", lo_out, 32'hFFFF_FFD6);
    repeat (3) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
